spi_flash_streamer: RTL and testbench

Parametrised SPI flash read engine for the VGA/SPI-ROM design. Pixel or line-buffer logic drives it with a start address and word count. It issues a mode-0 READ (optionally FAST READ) and streams back fixed-width words with a one-cycle valid strobe. It sits between the display logic and the external SPI flash pins (`spi_cs_n`, `spi_sclk`, `spi_mosi`, `spi_miso`) and runs on the pixel clock.

---
 rtl/spi_flash_streamer.sv | 176 +++++++++++++++++
 tb/tb_spi_flash_streamer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_streamer.sv
// SPI flash read engine: mode-0 READ (0x03) streaming fixed-width words back to display logic.
// Define SPI_FAST_READ_EN to issue FAST READ (0x0B) with an 8-bit dummy phase.
module spi_flash_streamer #(
  parameter int ADDR_BITS = 24,
  parameter int WORD_BITS = 8,
  parameter int LEN_BITS  = 10,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LEN_BITS-1:0]  len,
  input  logic                 abort,
  output logic                 busy,
  output logic [WORD_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 done,
  output logic                 spi_cs_n,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam logic [7:0] CMD = 8'h03;
`endif
  localparam int TX_W    = 8 + ADDR_BITS;
  localparam int CNT_MAX = (ADDR_BITS > 16) ? ADDR_BITS : 16;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GAP_W   = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef SPI_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_GAP
  } state_t;

  state_t               state, state_d;
  logic                 phase;
  logic [CNT_W-1:0]     bit_cnt;
  logic [LEN_BITS-1:0]  word_cnt, len_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TX_W-1:0]      tx_sr;
  logic [WORD_BITS-1:0] shift_q, shift_nx;
  logic                 active, last_bit, last_word, gap_end;
  logic                 accept, samp, finish;

  always_comb begin
    last_bit = 1'b0;
    case (state)
      S_CMD:   last_bit = (bit_cnt == CNT_W'(7));
      S_ADDR:  last_bit = (bit_cnt == CNT_W'(ADDR_BITS - 1));
`ifdef SPI_FAST_READ_EN
      S_DUMMY: last_bit = (bit_cnt == CNT_W'(7));
`endif
      S_DATA:  last_bit = (bit_cnt == CNT_W'(WORD_BITS - 1));
      default: last_bit = 1'b0;
    endcase
  end

  always_comb begin
    active    = (state != S_IDLE) && (state != S_GAP);
    last_word = (word_cnt == len_q);
    gap_end   = (gap_cnt == GAP_W'(CS_GAP - 1));
    accept    = (state == S_IDLE) && start;
    // Sampling edge is the one that raises sclk (phase 0 -> 1)
    samp      = (state == S_DATA) && !phase && !abort;
    finish    = (state == S_DATA) && phase && last_bit && last_word && !abort;
    shift_nx  = (shift_q << 1) | WORD_BITS'(spi_miso);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = S_CMD;
      S_CMD: begin
        if (abort) state_d = S_GAP;
        else if (phase && last_bit) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (abort) state_d = S_GAP;
`ifdef SPI_FAST_READ_EN
        else if (phase && last_bit) state_d = S_DUMMY;
      end
      S_DUMMY: begin
        if (abort) state_d = S_GAP;
`endif
        else if (phase && last_bit) state_d = S_DATA;
      end
      S_DATA: begin
        if (abort || finish) state_d = S_GAP;
      end
      S_GAP: if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      gap_cnt    <= '0;
      tx_sr      <= '0;
      shift_q    <= '0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        spi_cs_n <= 1'b0;
        spi_sclk <= 1'b0;
        spi_mosi <= CMD[7];
        // Zeros shifted in behind the address keep mosi low after the header
        tx_sr    <= {CMD[6:0], addr, 1'b0};
        phase    <= 1'b0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        len_q    <= len;
      end else if (active && (abort || finish)) begin
        spi_cs_n <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
        phase    <= 1'b0;
        gap_cnt  <= '0;
        done     <= finish;
      end else if (active) begin
        phase    <= ~phase;
        spi_sclk <= ~phase;
        if (!phase) begin
          if (samp) begin
            shift_q <= shift_nx;
            if (last_bit) begin
              data       <= shift_nx;
              data_valid <= 1'b1;
            end
          end
        end else begin
          spi_mosi <= tx_sr[TX_W-1];
          tx_sr    <= {tx_sr[TX_W-2:0], 1'b0};
          if (last_bit) begin
            bit_cnt <= '0;
            if (state == S_DATA) word_cnt <= word_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else if (state == S_GAP) begin
        if (gap_end) busy <= 1'b0;
        else         gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_streamer.sv
// Bench for spi_flash_streamer: table vectors, random reads against a word-level flash model,
// and hand sequences for abort, back-to-back, 9-bit burst and async reset.
module tb_spi_flash_streamer;
`ifdef SPI_FAST_READ_EN
  localparam int FRB = 8;
  localparam logic [7:0] CMD_EXP = 8'h0B;
`else
  localparam int FRB = 0;
  localparam logic [7:0] CMD_EXP = 8'h03;
`endif
  localparam int FR = 2 * FRB;
  localparam int P0 = 8 + 24 + FRB;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, miso = 1'b0;
  logic [23:0] addr = '0;
  logic [9:0]  len = '0;
  logic busy, data_valid, done, cs_n, sclk, mosi;
  logic [7:0] data;
  logic start9 = 1'b0, abort9 = 1'b0, miso9 = 1'b0;
  logic [23:0] addr9 = '0;
  logic [9:0]  len9 = '0;
  logic busy9, dv9, done9, cs9, sclk9, mosi9;
  logic [8:0] data9;

  spi_flash_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len), .abort(abort),
    .busy(busy), .data(data), .data_valid(data_valid), .done(done),
    .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso));

  spi_flash_streamer #(.WORD_BITS(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .addr(addr9), .len(len9), .abort(abort9),
    .busy(busy9), .data(data9), .data_valid(dv9), .done(done9),
    .spi_cs_n(cs9), .spi_sclk(sclk9), .spi_mosi(mosi9), .spi_miso(miso9));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0, nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash model: word array per device, bit stream addressed by count of sclk rises
  logic [15:0] fw [2][16];
  int          nrise [2];
  logic        p_sc [2];
  logic        p_cs_f [2];
  logic [31:0] mcap [2];

  task automatic fl_step(input int i, input logic cs, input logic sc, input logic mo,
                         input int w, output logic mi);
    int b;
    if (!cs && p_cs_f[i]) begin nrise[i] = 0; mcap[i] = '0; end
    if (!cs && sc && !p_sc[i]) begin
      if (nrise[i] < 32) mcap[i] = {mcap[i][30:0], mo};
      nrise[i]++;
    end
    p_sc[i] = sc;
    p_cs_f[i] = cs;
    b = nrise[i] - P0;
    if (!cs && b >= 0 && b / w < 16) mi = fw[i][b / w][w - 1 - b % w];
    else mi = 1'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin nrise[i] = 0; p_sc[i] = 0; p_cs_f[i] = 1; mcap[i] = '0; end
  end

  always @(negedge clk) begin
    logic m;
    fl_step(0, cs_n, sclk, mosi, 8, m);
    miso = m;
    fl_step(1, cs9, sclk9, mosi9, 9, m);
    miso9 = m;
  end

  int cs_fall[$], cs_rise[$], dv_cyc[$], done_cyc[$], busy_fall[$];
  logic [15:0] dv_dat[$];
  int dv9_cyc[$], done9_cyc[$];
  logic [15:0] dv9_dat[$];
  logic p_cs = 1'b1, p_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (p_cs && !cs_n) cs_fall.push_back(cyc);
    if (!p_cs && cs_n) cs_rise.push_back(cyc);
    if (data_valid) begin dv_cyc.push_back(cyc); dv_dat.push_back(16'(data)); end
    if (done) done_cyc.push_back(cyc);
    if (p_busy && !busy) busy_fall.push_back(cyc);
    if (dv9) begin dv9_cyc.push_back(cyc); dv9_dat.push_back(16'(data9)); end
    if (done9) done9_cyc.push_back(cyc);
    p_cs = cs_n;
    p_busy = busy;
  end

  task automatic clear_mon();
    cs_fall.delete(); cs_rise.delete(); dv_cyc.delete(); dv_dat.delete();
    done_cyc.delete(); busy_fall.delete();
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 5000) begin @(negedge clk); n++; end
    chk("wait_cycle", 64'(cyc), 64'(t));
  endtask

  task automatic wait_idle(input string name, input logic b9);
    int n = 0;
    while ((b9 ? busy9 : busy) && n < 4000) begin @(negedge clk); n++; end
    if (b9 ? busy9 : busy) begin
      ntests++; nfail++;
      $display("FAIL %s: busy still high after %0d cycles", name, n);
    end
  endtask

  function automatic int first_or_neg(input int q[$], input int base);
    return (q.size() > 0) ? q[0] - base : -1;
  endfunction

  // One read on the 8-bit device; timings are relative to the accepting edge E0
  task automatic txn0(input logic [23:0] a, input logic [9:0] l, input int ab, input int w0,
                      input int nw, input int d_off, input int cr_off, input int bf_off);
    int e;
    for (int k = 0; k < 16; k++) fw[0][k] = 16'($urandom_range(0, 255));
    if (w0 >= 0) fw[0][0] = 16'(w0);
    clear_mon();
    @(negedge clk); addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", 64'(busy), 64'd1);
    e = cyc;
    @(negedge clk); start = 1'b0; addr = 24'($urandom); len = 10'($urandom);
    if (ab > 0) begin
      wait_cyc(e + ab);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
    end
    wait_idle("txn_idle", 1'b0);
    repeat (2) @(negedge clk);
    chk("dv_count", 64'(dv_cyc.size()), 64'(nw));
    for (int k = 0; k < dv_cyc.size(); k++) begin
      chk("dv_time", 64'(dv_cyc[k] - e), 64'(2 * (P0 + (k + 1) * 8) - 1));
      chk("dv_data", 64'(dv_dat[k]), 64'(fw[0][k]));
    end
    if (nw > 0) chk("data_hold", 64'(data), 64'(fw[0][nw - 1]));
    if (d_off > 0) chk("done_time", 64'(first_or_neg(done_cyc, e)), 64'(d_off));
    chk("done_count", 64'(done_cyc.size()), (d_off > 0) ? 64'd1 : 64'd0);
    chk("cs_rise", 64'(first_or_neg(cs_rise, e)), 64'(cr_off));
    chk("busy_fall", 64'(first_or_neg(busy_fall, e)), 64'(bf_off));
    if (ab == 0) chk("mosi_stream", 64'(mcap[0]), 64'({CMD_EXP, a}));
  endtask

  typedef struct {
    logic [23:0] a;
    logic [9:0]  l;
    int ab, w0, nw, d_off, cr_off, bf_off;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int e, n;
    tbl[0] = '{24'h012345, 10'd0, 0, 'hA5, 1, 80 + FR, 80 + FR, 82 + FR};
    tbl[1] = '{24'hABCDEF, 10'd2, 0, -1, 3, 112 + FR, 112 + FR, 114 + FR};
    tbl[2] = '{24'h000000, 10'd0, 50, -1, 0, 0, 51, 53};
    tbl[3] = '{24'h7FFFFF, 10'd0, 78 + FR, -1, 0, 0, 79 + FR, 81 + FR};
    tbl[4] = '{24'h800000, 10'd0, 79 + FR, -1, 1, 0, 80 + FR, 82 + FR};
    tbl[5] = '{24'hFFFFFF, 10'd1, 2, -1, 0, 0, 3, 5};

    // Reset held with start high: nothing moves
    start = 1'b1; start9 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_sclk", 64'(sclk), 64'd0);
      chk("rst_cs_n", 64'(cs_n), 64'd1);
    end
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cs9", 64'(cs9), 64'd1);
    start = 1'b0; start9 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i])
      txn0(tbl[i].a, tbl[i].l, tbl[i].ab, tbl[i].w0, tbl[i].nw, tbl[i].d_off,
           tbl[i].cr_off, tbl[i].bf_off);

    // Random reads: timings and data from the word-level model
    for (int r = 0; r < 8; r++) begin
      logic [23:0] a;
      int l;
      a = 24'($urandom);
      l = $urandom_range(0, 3);
      txn0(a, 10'(l), 0, -1, l + 1, 2 * (P0 + (l + 1) * 8), 2 * (P0 + (l + 1) * 8),
           2 * (P0 + (l + 1) * 8) + 2);
    end

    // Abort at E0+50, start held from E0+51: accepted only at E0+54
    clear_mon();
    @(negedge clk); addr = 24'h135790; len = 10'd0; start = 1'b1;
    @(posedge clk); #1; e = cyc;
    @(negedge clk); start = 1'b0;
    wait_cyc(e + 50);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b1;
    n = 0;
    while (cs_fall.size() < 2 && n < 200) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("abort_cs_rise", 64'(first_or_neg(cs_rise, e)), 64'd51);
    chk("restart_e0", 64'(cs_fall.size() > 1 ? cs_fall[1] - e : -1), 64'd54);
    chk("abort_no_dv", 64'(dv_cyc.size()), 64'd0);
    chk("abort_no_done", 64'(done_cyc.size()), 64'd0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle("abort_idle", 1'b0);

    // Back-to-back with start held: CS high CS_GAP+1 cycles, new addr captured
    for (int k = 0; k < 16; k++) fw[0][k] = 16'($urandom_range(0, 255));
    clear_mon();
    @(negedge clk); addr = 24'h2468AC; len = 10'd0; start = 1'b1;
    n = 0;
    while (cs_fall.size() < 1 && n < 50) begin @(negedge clk); n++; end
    addr = 24'hC0FFEE;
    n = 0;
    while (cs_fall.size() < 2 && n < 300) begin @(negedge clk); n++; end
    start = 1'b0;
    wait_idle("b2b_idle", 1'b0);
    repeat (2) @(negedge clk);
    chk("b2b_cs_low", 64'(cs_rise.size() > 0 && cs_fall.size() > 0 ? cs_rise[0] - cs_fall[0] : -1),
        64'(80 + FR));
    chk("b2b_cs_high", 64'(cs_rise.size() > 0 && cs_fall.size() > 1 ? cs_fall[1] - cs_rise[0] : -1),
        64'd3);
    chk("b2b_mosi", 64'(mcap[0]), 64'({CMD_EXP, 24'hC0FFEE}));
    chk("b2b_dv_count", 64'(dv_cyc.size()), 64'd2);
    chk("b2b_done_count", 64'(done_cyc.size()), 64'd2);

    // 9-bit burst of four words
    fw[1][0] = 16'h1FF; fw[1][1] = 16'h000; fw[1][2] = 16'h155; fw[1][3] = 16'h0AA;
    dv9_cyc.delete(); dv9_dat.delete(); done9_cyc.delete();
    @(negedge clk); addr9 = 24'h000100; len9 = 10'd3; start9 = 1'b1;
    @(posedge clk); #1; e = cyc;
    @(negedge clk); start9 = 1'b0;
    wait_idle("burst_idle", 1'b1);
    repeat (2) @(negedge clk);
    chk("burst_dv_count", 64'(dv9_cyc.size()), 64'd4);
    for (int k = 0; k < dv9_cyc.size(); k++) begin
      chk("burst_dv_time", 64'(dv9_cyc[k] - e), 64'(2 * (P0 + (k + 1) * 9) - 1));
      chk("burst_dv_data", 64'(dv9_dat[k]), 64'(fw[1][k]));
    end
    chk("burst_done_count", 64'(done9_cyc.size()), 64'd1);
    chk("burst_done_time", 64'(first_or_neg(done9_cyc, e)), 64'(2 * (P0 + 36)));

    // Asynchronous reset in the middle of a read
    for (int k = 0; k < 16; k++) fw[0][k] = 16'h0FF;
    txn0(24'h000040, 10'd0, 0, -1, 1, 80 + FR, 80 + FR, 82 + FR);
    @(negedge clk); addr = 24'h00ABCD; len = 10'd5; start = 1'b1;
    @(posedge clk); #1; e = cyc;
    @(negedge clk); start = 1'b0;
    wait_cyc(e + 30);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 64'(cs_n), 64'd1);
    chk("arst_sclk", 64'(sclk), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_data", 64'(data), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_stays_idle", 64'({busy, cs_n, sclk}), 64'b010);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
